// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, status-flag layout and control states.
// Compile with ALU_MUL_EN defined to build the iterative multiplier.
package alu_pkg;

  typedef enum logic [3:0] {
    OpAdd  = 4'd0,
    OpAddc = 4'd1,
    OpSub  = 4'd2,
    OpSubb = 4'd3,
    OpAnd  = 4'd4,
    OpOr   = 4'd5,
    OpXor  = 4'd6,
    OpNot  = 4'd7,
    OpLoad = 4'd8,
    OpShl  = 4'd9,
    OpShr  = 4'd10,
    OpMul  = 4'd11
  } instruction_code_e;

  typedef struct packed {
    logic c;
    logic v;
    logic n;
    logic z;
  } alu_flags_t;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } alu_state_e;

  // Highest defined opcode; anything above decodes as LOAD.
  localparam int unsigned OpLastCode = 11;

endpackage

// File: rtl/alu_if.sv
// Operation/result handshake bundle between the decode stage, the ALU and writeback.
interface alu_if #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned OPCODE_WIDTH = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [OPCODE_WIDTH-1:0] op_code;
  logic [DATA_WIDTH-1:0]   i_1;
  logic [DATA_WIDTH-1:0]   i_2;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   o_main;
  logic [3:0]              o_flags;
  logic                    busy;

  modport master (
    output in_valid, op_code, i_1, i_2, out_ready,
    input  in_ready, out_valid, o_main, o_flags, busy
  );

  modport slave (
    input  in_valid, op_code, i_1, i_2, out_ready,
    output in_ready, out_valid, o_main, o_flags, busy
  );
endinterface

// File: rtl/alu_iter_unit.sv
// Bit-serial shifter and (with ALU_MUL_EN) shift-add multiplier; one step per cycle.
// done flags the cycle whose step is the last one; res/c_out then hold the final values.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_W      = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  instruction_code_e     op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [CNT_W-1:0]      count,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] res,
  output logic                  c_out
);
  localparam int unsigned MSB = DATA_WIDTH - 1;

  instruction_code_e r_op;
  logic [CNT_W-1:0]  r_cnt;
  logic [MSB:0]      r_lo;
  logic [MSB:0]      w_lo_d;
`ifdef ALU_MUL_EN
  logic [MSB:0]      r_hi;
  logic [MSB:0]      r_a;
  logic [MSB:0]      w_hi_d;
  logic [MSB+1:0]    w_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op  <= OpLoad;
      r_cnt <= '0;
      r_lo  <= '0;
`ifdef ALU_MUL_EN
      r_hi  <= '0;
      r_a   <= '0;
`endif
    end else if (start) begin
      r_op  <= op;
      r_cnt <= count;
      // Multiplier keeps B in the low half and consumes it from bit 0.
      r_lo  <= (op == OpMul) ? b : a;
`ifdef ALU_MUL_EN
      r_hi  <= '0;
      r_a   <= a;
`endif
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
      r_lo  <= w_lo_d;
`ifdef ALU_MUL_EN
      r_hi  <= w_hi_d;
`endif
    end
  end

  always_comb begin
    w_lo_d = r_lo;
    c_out  = 1'b0;
`ifdef ALU_MUL_EN
    w_hi_d = r_hi;
    w_sum  = '0;
`endif
    unique case (r_op)
      OpShl: begin
        w_lo_d = {r_lo[MSB-1:0], 1'b0};
        c_out  = r_lo[MSB];
      end
      OpShr: begin
        w_lo_d = {1'b0, r_lo[MSB:1]};
        c_out  = r_lo[0];
      end
`ifdef ALU_MUL_EN
      OpMul: begin
        w_sum            = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
        {w_hi_d, w_lo_d} = {w_sum, r_lo[MSB:1]};
        c_out            = |w_hi_d;
      end
`endif
      default: ;
    endcase
  end

  assign done = (r_cnt == CNT_W'(1));
  assign res  = w_lo_d;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, carry register and Z/N/C/V flags.
// Define ALU_MUL_EN to enable the iterative MUL; otherwise MUL executes as LOAD.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned OPCODE_WIDTH = 4
) (
  input logic  clk,
  input logic  rst_n,
  alu_if.slave bus
);
  localparam int unsigned SHAMT_W = $clog2(DATA_WIDTH);
  localparam int unsigned CNT_W   = SHAMT_W + 1;
  localparam int unsigned MSB     = DATA_WIDTH - 1;

  alu_state_e        r_state, w_state_d;
  logic [MSB:0]      r_main;
  alu_flags_t        r_flags, w_flags_d, w_iter_flags;
  logic              r_creg;

  instruction_code_e w_op;
  logic [MSB:0]      w_a, w_b, w_res, w_iter_res;
  logic [MSB+1:0]    w_sum;
  logic              w_c, w_v, w_iter, w_accept, w_iter_done, w_iter_c, w_out_fire;
  logic [SHAMT_W-1:0] w_shamt;
  logic [CNT_W-1:0]  w_cnt;

  assign w_a        = bus.i_1;
  assign w_b        = bus.i_2;
  assign w_shamt    = bus.i_2[SHAMT_W-1:0];
  assign w_accept   = bus.in_valid && (r_state == StIdle);
  assign w_out_fire = (r_state == StDone) && bus.out_ready;

  always_comb begin
    w_op = (bus.op_code > OPCODE_WIDTH'(OpLastCode)) ? OpLoad
                                                     : instruction_code_e'(bus.op_code[3:0]);
`ifndef ALU_MUL_EN
    if (w_op == OpMul) w_op = OpLoad;
`endif
    w_iter = ((w_op == OpShl) || (w_op == OpShr)) && (w_shamt != '0);
`ifdef ALU_MUL_EN
    if (w_op == OpMul) w_iter = 1'b1;
`endif
    w_cnt = (w_op == OpMul) ? CNT_W'(DATA_WIDTH) : CNT_W'(w_shamt);
  end

  // Single-cycle datapath, evaluated on the accept cycle straight from the bus operands.
  always_comb begin
    w_sum = '0;
    w_res = w_b;
    w_c   = r_creg;
    w_v   = 1'b0;
    unique case (w_op)
      OpAdd, OpAddc: begin
        w_sum = {1'b0, w_a} + {1'b0, w_b} + ((w_op == OpAddc) ? (MSB+2)'(r_creg) : '0);
        w_res = w_sum[MSB:0];
        w_c   = w_sum[MSB+1];
        w_v   = (w_a[MSB] == w_b[MSB]) && (w_res[MSB] != w_a[MSB]);
      end
      OpSub, OpSubb: begin
        w_sum = {1'b0, w_a} - {1'b0, w_b} - ((w_op == OpSubb) ? (MSB+2)'(r_creg) : '0);
        w_res = w_sum[MSB:0];
        w_c   = w_sum[MSB+1];
        w_v   = (w_a[MSB] != w_b[MSB]) && (w_res[MSB] != w_a[MSB]);
      end
      OpAnd:        w_res = w_a & w_b;
      OpOr:         w_res = w_a | w_b;
      OpXor:        w_res = w_a ^ w_b;
      OpNot:        w_res = ~w_a;
      OpShl, OpShr: w_res = w_a;
      default:      w_res = w_b;
    endcase
    w_flags_d    = '{c: w_c, v: w_v, n: w_res[MSB], z: (w_res == '0)};
    w_iter_flags = '{c: w_iter_c, v: 1'b0, n: w_iter_res[MSB], z: (w_iter_res == '0)};
  end

  alu_iter_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_accept && w_iter),
    .op    (w_op),
    .a     (w_a),
    .b     (w_b),
    .count (w_cnt),
    .done  (w_iter_done),
    .res   (w_iter_res),
    .c_out (w_iter_c)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_d = w_iter ? StBusy : StDone;
      StBusy:  if (w_iter_done) w_state_d = StDone;
      StDone:  if (bus.out_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_main  <= '0;
      r_flags <= '0;
      r_creg  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept && !w_iter) begin
        r_main  <= w_res;
        r_flags <= w_flags_d;
      end else if ((r_state == StBusy) && w_iter_done) begin
        r_main  <= w_iter_res;
        r_flags <= w_iter_flags;
      end
      // Carry only advances once the consumer has taken the result.
      if (w_out_fire) r_creg <= r_flags.c;
    end
  end

  assign bus.in_ready  = (r_state == StIdle);
  assign bus.out_valid = (r_state == StDone);
  assign bus.busy      = (r_state == StBusy);
  assign bus.o_main    = r_main;
  assign bus.o_flags   = r_flags;

endmodule
